// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Bundles the two requester ports, the response outputs and the
//            external ALU connection of the shared-ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CONF_W = 5
);
  // Requester 0 (PC / branch-target path)
  logic              req0;
  logic [CONF_W-1:0] conf0;
  logic              sign0;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;
  // Requester 1 (instruction execute path)
  logic              req1;
  logic [CONF_W-1:0] conf1;
  logic              sign1;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  b1;
  // Response
  logic              done0;
  logic              done1;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              busy;
  // External ALU
  logic [CONF_W-1:0] alu_conf;
  logic              alu_sign;
  logic [WIDTH-1:0]  alu_in1;
  logic [WIDTH-1:0]  alu_in2;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  // Arbiter side
  modport slave (
    input  req0, conf0, sign0, a0, b0,
    input  req1, conf1, sign1, a1, b1,
    output done0, done1, result, zero, busy,
    output alu_conf, alu_sign, alu_in1, alu_in2,
    input  alu_result, alu_zero
  );

  // Requester / ALU environment side
  modport master (
    output req0, conf0, sign0, a0, b0,
    output req1, conf1, sign1, a1, b1,
    input  done0, done1, result, zero, busy,
    input  alu_conf, alu_sign, alu_in1, alu_in2,
    output alu_result, alu_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one external combinational ALU between
//            two requesters. Operands are latched, the ALU is driven from
//            registers, and the registered result returns with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CONF_W = 5
) (
  input  wire                  clk,
  input  wire                  reset,
  alu_share_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic              r_gnt;     // port currently being served
  logic              r_rr;      // port preferred on a tie
  logic [CONF_W-1:0] r_conf;
  logic              r_sign;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_zero;

  logic              w_any_req;
  logic              w_pick;

  // Winner selection: a lone requester wins, a tie goes to the round-robin pointer
  assign w_any_req = bus.req0 | bus.req1;
  assign w_pick    = (bus.req0 & bus.req1) ? r_rr : bus.req1;

  // Control FSM: grant, step through latch/exec, respond and rotate priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick;
            r_state <= S_LATCH;
          end
        end
        S_LATCH: r_state <= S_EXEC;
        S_EXEC:  r_state <= S_RESP;
        S_RESP: begin
          r_rr    <= ~r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: take the winner's operands in LATCH, capture the ALU output in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf   <= '0;
      r_sign   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (r_state == S_LATCH) begin
        r_conf <= r_gnt ? bus.conf1 : bus.conf0;
        r_sign <= r_gnt ? bus.sign1 : bus.sign0;
        r_a    <= r_gnt ? bus.a1    : bus.a0;
        r_b    <= r_gnt ? bus.b1    : bus.b0;
      end
      if (r_state == S_EXEC) begin
        r_result <= bus.alu_result;
        r_zero   <= bus.alu_zero;
      end
    end
  end

  // All outputs are decoded from registers only, so no requester input reaches them
  assign bus.done0    = (r_state == S_RESP) & ~r_gnt;
  assign bus.done1    = (r_state == S_RESP) &  r_gnt;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.alu_conf = r_conf;
  assign bus.alu_sign = r_sign;
  assign bus.alu_in1  = r_a;
  assign bus.alu_in2  = r_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with a small
//            behavioural ALU attached to the ALU-side signals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CONF_W = 5;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .CONF_W(CONF_W)) bif ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CONF_W(CONF_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the shared ALU port
  logic [WIDTH-1:0] m_res;
  always_comb begin
    m_res = '0;
    case (bif.alu_conf)
      OP_ADD: m_res = bif.alu_in1 + bif.alu_in2;
      OP_AND: m_res = bif.alu_in1 & bif.alu_in2;
      OP_OR:  m_res = bif.alu_in1 | bif.alu_in2;
      OP_SUB: m_res = bif.alu_in1 - bif.alu_in2;
      OP_SLT: m_res = bif.alu_sign ?
                      {31'd0, ($signed(bif.alu_in1) < $signed(bif.alu_in2))} :
                      {31'd0, (bif.alu_in1 < bif.alu_in2)};
      default: m_res = '0;
    endcase
  end
  assign bif.alu_result = m_res;
  assign bif.alu_zero   = (m_res == '0);

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a done pulse; returns which port and how many edges it took
  task automatic wait_done(input string tag, output int port, output int lat);
    logic found;
    found = 1'b0;
    port  = -1;
    lat   = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      lat++;
      if (bif.done0 || bif.done1) begin
        found = 1'b1;
        port  = bif.done0 ? 0 : 1;
        check_value({tag, "_onehot"}, {31'd0, bif.done0 & bif.done1}, 32'd0);
        break;
      end
    end
    check_value({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  int port;
  int lat;
  int busy_cnt;
  int done_cnt;
  int chg_cnt;
  int order[4];

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bif.req0 = 1'b0; bif.conf0 = '0; bif.sign0 = 1'b0; bif.a0 = '0; bif.b0 = '0;
    bif.req1 = 1'b0; bif.conf1 = '0; bif.sign1 = 1'b0; bif.a1 = '0; bif.b1 = '0;

    // ---------------- reset state ----------------
    repeat (3) step();
    check_value("rst_busy",   {31'd0, bif.busy}, 32'd0);
    check_value("rst_done",   {30'd0, bif.done1, bif.done0}, 32'd0);
    check_value("rst_result", bif.result, 32'd0);
    check_value("rst_zero",   {31'd0, bif.zero}, 32'd0);
    check_value("rst_alu_in", bif.alu_in1 | bif.alu_in2 | {27'd0, bif.alu_conf}, 32'd0);
    reset = 1'b0;
    step();

    // ---------------- single request on port 0: 5 + 7 ----------------
    bif.req0 = 1'b1; bif.conf0 = OP_ADD; bif.a0 = 32'd5; bif.b0 = 32'd7;
    wait_done("t1", port, lat);
    check_value("t1_port",   port, 0);
    check_value("t1_lat",    lat, 3);
    check_value("t1_result", bif.result, 32'd12);
    check_value("t1_zero",   {31'd0, bif.zero}, 32'd0);
    check_value("t1_done1",  {31'd0, bif.done1}, 32'd0);
    bif.req0 = 1'b0;
    step();
    check_value("t1_pulse_len", {31'd0, bif.done0}, 32'd0);
    check_value("t1_idle_busy", {31'd0, bif.busy}, 32'd0);

    // ---------------- single request on port 1: 3 - 3 ----------------
    bif.req1 = 1'b1; bif.conf1 = OP_SUB; bif.a1 = 32'h3; bif.b1 = 32'h3;
    wait_done("t2", port, lat);
    check_value("t2_port",   port, 1);
    check_value("t2_lat",    lat, 3);
    check_value("t2_result", bif.result, 32'd0);
    check_value("t2_zero",   {31'd0, bif.zero}, 32'd1);
    bif.req1 = 1'b0;
    step();

    // ---------------- both held: alternation 0,1,0,1 ----------------
    bif.req0 = 1'b1; bif.conf0 = OP_ADD; bif.a0 = 32'd1;    bif.b0 = 32'd1;
    bif.req1 = 1'b1; bif.conf1 = OP_OR;  bif.a1 = 32'hF0;   bif.b1 = 32'h0F;
    for (int k = 0; k < 4; k++) begin
      wait_done("t3", port, lat);
      order[k] = port;
      check_value("t3_lat", lat, (k == 0) ? 3 : 4);
      check_value("t3_result", bif.result, (port == 0) ? 32'd2 : 32'hFF);
    end
    check_value("t3_order0", order[0], 0);
    check_value("t3_order1", order[1], 1);
    check_value("t3_order2", order[2], 0);
    check_value("t3_order3", order[3], 1);
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    step();

    // ---------------- operand latching: signed compare -1 < 1 ----------------
    bif.req0 = 1'b1; bif.conf0 = OP_SLT; bif.sign0 = 1'b1;
    bif.a0 = 32'hFFFF_FFFF; bif.b0 = 32'd1;
    step();                 // grant edge -> LATCH
    step();                 // latch edge -> EXEC
    check_value("t4_alu_in1",  bif.alu_in1, 32'hFFFF_FFFF);
    check_value("t4_alu_sign", {31'd0, bif.alu_sign}, 32'd1);
    bif.a0 = 32'd5;         // must not affect the operation in flight
    wait_done("t4", port, lat);
    check_value("t4_port",   port, 0);
    check_value("t4_lat",    lat, 1);
    check_value("t4_result", bif.result, 32'd1);
    bif.req0 = 1'b0; bif.sign0 = 1'b0;
    step();

    // ---------------- reset during EXEC of a port-1 op ----------------
    bif.req1 = 1'b1; bif.conf1 = OP_ADD; bif.a1 = 32'd2; bif.b1 = 32'd3;
    step();
    step();
    check_value("t5_busy_exec", {31'd0, bif.busy}, 32'd1);
    reset = 1'b1;
    bif.req0 = 1'b1; bif.conf0 = OP_ADD; bif.a0 = 32'd1; bif.b0 = 32'd1;
    #1;
    check_value("t5_rst_busy",   {31'd0, bif.busy}, 32'd0);
    check_value("t5_rst_result", bif.result, 32'd0);
    check_value("t5_rst_in1",    bif.alu_in1, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bif.done0 || bif.done1) done_cnt++;
    end
    check_value("t5_no_done", done_cnt, 0);
    reset = 1'b0;
    wait_done("t5", port, lat);
    check_value("t5_port",   port, 0);
    check_value("t5_lat",    lat, 3);
    check_value("t5_result", bif.result, 32'd2);
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    step();

    // ---------------- idle stability for 20 cycles ----------------
    busy_cnt = 0; done_cnt = 0; chg_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bif.busy) busy_cnt++;
      if (bif.done0 || bif.done1) done_cnt++;
      if (bif.result !== 32'd2 || bif.zero !== 1'b0) chg_cnt++;
    end
    check_value("t6_busy",   busy_cnt, 0);
    check_value("t6_done",   done_cnt, 0);
    check_value("t6_hold",   chg_cnt, 0);
    check_value("t6_result", bif.result, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 (PC/branch-target path) and port 1 (instruction execute path).
- Arbitrates round-robin, latches the winner's operands, drives the ALU from registers, captures Result/Zero, and returns them with a one-cycle done pulse.
- Sits between the multi-cycle controller's datapath muxes and the ALU; the ALU itself is external.

Parameters:
- WIDTH, 32, data width of operands and result.
- CONF_W, 5, width of the ALU operation code (ALUConf).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high with operands stable until done0.
- conf0  input  CONF_W  requester 0 ALU operation code.
- sign0  input  1  requester 0 signed-compare select.
- a0  input  WIDTH  requester 0 operand In1.
- b0  input  WIDTH  requester 0 operand In2.
- req1, conf1, sign1, a1, b1: same as port 0, for requester 1.
- done0  output  1  one-cycle pulse; result/zero valid for requester 0.
- done1  output  1  one-cycle pulse; result/zero valid for requester 1.
- result  output  WIDTH  registered ALU result of the last completed operation.
- zero  output  1  registered ALU Zero flag of the last completed operation.
- busy  output  1  high while in LATCH, EXEC or RESP.
- alu_conf  output  CONF_W  to ALU ALUConf.
- alu_sign  output  1  to ALU Sign.
- alu_in1  output  WIDTH  to ALU In1.
- alu_in2  output  WIDTH  to ALU In2.
- alu_result  input  WIDTH  from ALU Result.
- alu_zero  input  1  from ALU Zero.

Behaviour:
- Reset (async, any state): state=IDLE; done0=done1=0; result=0; zero=0; busy=0; operand/conf/sign registers=0; rr_ptr=0 (port 0 preferred).
- ALU drive: alu_conf/sign/in1/in2 always come from the operand registers, never directly from requester ports. Value is 0 after reset.
- FSM states: IDLE, LATCH, EXEC, RESP.
- IDLE: sample req0/req1.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted: grant port rr_ptr.
  - On any grant: record grant_id; go to LATCH.
- LATCH: register conf/sign/a/b of grant_id; go to EXEC.
- EXEC: ALU inputs are stable from the registers. At the clock edge, capture alu_result into result and alu_zero into zero; go to RESP.
- RESP: done[grant_id]=1 for exactly this cycle; the other done stays 0. Set rr_ptr = ~grant_id. Go to IDLE.
- Latency: req sampled in IDLE at edge N, then done high during cycle N+3. Throughput is one operation per 4 cycles.
- result/zero hold their value after RESP until the next EXEC capture.
- Requester contract: deassert req at the edge ending the done cycle, or keep it high to issue a new request. A still-high req in the following IDLE is a new request.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1,...
- Requester-side changes in LATCH/EXEC/RESP are ignored. Operands are taken only in LATCH.
- A req dropped after grant does not cancel the operation; done still pulses.
- busy = (state != IDLE).
- Reset mid-operation: operation discarded, no done pulse; after release, rr_ptr=0.
- No combinational path from any requester input to any output.

Test Plan:
- Reset, then req0 with conf0=00000, a0=5, b0=7 -> done0 pulses 3 cycles after the grant edge; result=12, zero=0; done1 stays 0.
- req1 with conf1=00110, a1=b1=0x0000_0003 -> done1 pulse; result=0, zero=1.
- req0 and req1 asserted together and held: port 0 = add 1+1, port 1 = or 0xF0|0x0F -> done0 (result=2) first, then done1 (result=0xFF). Grant order continues 0,1,0,1 over 4 operations.
- req0 signed compare (conf=00111, sign=1, a=0xFFFF_FFFF, b=1): change a0 to 5 during EXEC -> result=1, proving operands were latched.
- Assert reset during EXEC of a req1 operation -> done1 never pulses; result=0. After release with both reqs high, port 0 is granted first.
- Idle stability: no requests for 20 cycles after a completed op -> busy=0, done0=done1=0, result/zero unchanged.
